// File: rtl/md5_brute_pkg.sv
// Shared definitions for the MD5 brute-force datapath: default widths/depth
// and the candidate source state encoding.
package md5_brute_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 32;
  localparam int unsigned DEFAULT_PIPE_DEPTH = 64;
  localparam int unsigned DEFAULT_DRAIN_W    = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cand_state_t;

endpackage

// File: rtl/md5_drain_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module md5_drain_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Load has priority; otherwise count down until zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/md5_candidate_source.sv
// Sequential candidate generator for the MD5 brute-force pipeline.
// Issues base..limit (inclusive) one per cycle, honours pause/abort, then
// waits PIPE_DEPTH cycles for the hash pipeline to drain before raising done.
// Optional macro MD5_CANDSRC_WRAP_EN: allows limit<base (run wraps through 0).
module md5_candidate_source
  import md5_brute_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned PIPE_DEPTH = DEFAULT_PIPE_DEPTH,
  parameter int unsigned DRAIN_W    = DEFAULT_DRAIN_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] limit,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] counter_out,
  output logic             counter_valid,
  output logic             busy,
  output logic             done,
  output logic             range_err,
  output logic [WIDTH:0]   issued_count
);

  // Loaded on the last issue so done lands PIPE_DEPTH cycles after it.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);

  cand_state_t      state;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] lim;
  logic             range_bad_c;
  logic             last_c;
  logic             drain_load_c;
  logic             drain_zero_c;

  // Reversed ranges are only legal when wrapping through zero is enabled.
`ifdef MD5_CANDSRC_WRAP_EN
  assign range_bad_c = 1'b0;
`else
  assign range_bad_c = (limit < base);
`endif

  assign last_c       = (cur == lim);
  assign drain_load_c = (state == ST_RUN) && !abort && !pause && last_c;

  md5_drain_timer #(
    .W (DRAIN_W)
  ) u_drain_timer (
    .clk        (CLK),
    .rst        (RST),
    .load       (drain_load_c),
    .load_value (DRAIN_LOAD),
    .zero_c     (drain_zero_c)
  );

  // Run control FSM with registered outputs; abort overrides everything but reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= ST_IDLE;
      cur           <= '0;
      lim           <= '0;
      counter_out   <= '0;
      counter_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      range_err     <= 1'b0;
      issued_count  <= '0;
    end else if (abort) begin
      state         <= ST_IDLE;
      counter_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (range_bad_c) begin
              range_err <= 1'b1;
            end else begin
              cur          <= base;
              lim          <= limit;
              issued_count <= '0;
              done         <= 1'b0;
              range_err    <= 1'b0;
              busy         <= 1'b1;
              state        <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            counter_valid <= 1'b0;
          end else begin
            counter_out   <= cur;
            counter_valid <= 1'b1;
            issued_count  <= issued_count + (WIDTH + 1)'(1);
            if (last_c) begin
              state <= ST_DRAIN;
            end else begin
              cur <= cur + WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          counter_valid <= 1'b0;
          if (drain_zero_c) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_candidate_source.sv
// Scoreboard bench for md5_candidate_source: stimulus pushes expected
// candidates, a negedge monitor pops and compares every valid output.
module tb_md5_candidate_source;

  localparam int unsigned W  = 32;
  localparam int unsigned PD = 64;

  logic          CLK   = 1'b0;
  logic          RST   = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  base  = '0;
  logic [W-1:0]  limit = '0;
  logic [W-1:0]  counter_out;
  logic          counter_valid;
  logic          busy;
  logic          done;
  logic          range_err;
  logic [W:0]    issued_count;

  int            total = 0;
  int            bad   = 0;
  logic [W-1:0]  exp_q[$];

  md5_candidate_source dut (
    .CLK           (CLK),
    .RST           (RST),
    .start         (start),
    .base          (base),
    .limit         (limit),
    .pause         (pause),
    .abort         (abort),
    .counter_out   (counter_out),
    .counter_valid (counter_valid),
    .busy          (busy),
    .done          (done),
    .range_err     (range_err),
    .issued_count  (issued_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid candidate must match the oldest expected value.
  always @(negedge CLK) begin
    if (!RST && counter_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got 0x%0h expected no candidate at %0t", counter_out, $time);
      end else begin
        chk("candidate", 64'(counter_out), 64'(exp_q.pop_front()));
      end
    end
  end

  // Reference candidate count for a small range.
  function automatic int cand_count(input logic [W-1:0] b, input logic [W-1:0] l);
`ifdef MD5_CANDSRC_WRAP_EN
    return int'(W'(l - b + W'(1)));
`else
    return (l < b) ? 0 : int'(l - b) + 1;
`endif
  endfunction

  // One complete run. mode: 0 plain, 1 pause on cycles 2-4, 2 random pause,
  // 3 extra start (with other range) while busy.
  task automatic run(input logic [W-1:0] b, input logic [W-1:0] l, input int mode);
    int   n;
    int   rem;
    int   last;
    int   k;
    int   bound;
    logic seen;
    n = cand_count(b, l);
    for (int i = 0; i < n; i++) exp_q.push_back(b + W'(i));
    @(posedge CLK); #1;
    start = 1'b1; base = b; limit = l;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("done_cleared", 64'(done), 64'd0);
    chk("range_err_cleared", 64'(range_err), 64'd0);
    rem = n; last = 0; k = 1; bound = n + int'(PD) + 40; seen = 1'b0;
    while (k <= bound && !seen) begin
      case (mode)
        1:       pause = (k >= 2 && k <= 4);
        2:       pause = ($urandom_range(3) == 0);
        default: pause = 1'b0;
      endcase
      if (mode == 3) begin
        start = (k == 2); base = ~b; limit = ~b;
      end
      @(posedge CLK);
      if (rem > 0 && !pause) begin
        rem--;
        if (rem == 0) last = k;
      end
      #1;
      if (done) seen = 1'b1;
      else k++;
    end
    pause = 1'b0; start = 1'b0; base = b; limit = l;
    chk("done_cycle", seen ? 64'(k) : 64'hFFFF_FFFF, 64'(last + int'(PD)));
    chk("issued_count", 64'(issued_count), 64'(n));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Watch for a spurious done over a window after an abort.
  task automatic no_done_window(input string name);
    logic any;
    any = 1'b0;
    repeat (80) begin
      @(posedge CLK); #1;
      any = any | done;
    end
    chk(name, 64'(any), 64'd0);
  endtask

  initial begin
    #1;
    chk("rst_counter_out", 64'(counter_out), 64'd0);
    chk("rst_valid", 64'(counter_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_range_err", 64'(range_err), 64'd0);
    chk("rst_issued", 64'(issued_count), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    run(32'h10, 32'h13, 0);
    run(32'd5, 32'd9, 1);

    // Abort in RUN right after 0x100 is issued.
    for (int i = 0; i < 5; i++) exp_q.push_back(32'hFC + W'(i));
    @(posedge CLK); #1;
    start = 1'b1; base = 32'hFC; limit = 32'h200;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1 abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    chk("abort_run_valid", 64'(counter_valid), 64'd0);
    chk("abort_run_busy", 64'(busy), 64'd0);
    chk("abort_run_issued", 64'(issued_count), 64'd5);
    chk("abort_run_queue", 64'(exp_q.size()), 64'd0);
    no_done_window("abort_run_no_done");

    // Abort during DRAIN.
    for (int i = 1; i <= 3; i++) exp_q.push_back(W'(i));
    @(posedge CLK); #1;
    start = 1'b1; base = 32'd1; limit = 32'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (13) @(posedge CLK);
    #1 abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    chk("abort_drain_busy", 64'(busy), 64'd0);
    chk("abort_drain_done", 64'(done), 64'd0);
    chk("abort_drain_issued", 64'(issued_count), 64'd3);
    no_done_window("abort_drain_no_done");

    run(32'h20, 32'h22, 3);
    run(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);

`ifdef MD5_CANDSRC_WRAP_EN
    run(32'hFFFF_FFFE, 32'd1, 0);
`else
    @(posedge CLK); #1;
    start = 1'b1; base = 32'hFFFF_FFFE; limit = 32'd1;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("reject_range_err", 64'(range_err), 64'd1);
    chk("reject_busy", 64'(busy), 64'd0);
    chk("reject_done_holds", 64'(done), 64'd1);
    chk("reject_issued_holds", 64'(issued_count), 64'd2);
`endif

    // start+abort together in DONE: abort wins.
    @(posedge CLK); #1;
    start = 1'b1; abort = 1'b1; base = 32'd0; limit = 32'd5;
    @(posedge CLK); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_done", 64'(done), 64'd0);
    chk("start_abort_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge CLK);
    #1 chk("start_abort_idle", 64'(busy), 64'd0);

    run(32'd7, 32'd7, 0);

    for (int r = 0; r < 6; r++) begin
      logic [W-1:0] b;
      int           n;
      b = W'($urandom) & 32'h7FFF_FFFF;
      n = int'($urandom_range(8, 1));
      run(b, b + W'(n - 1), 2);
    end

    // Asynchronous reset between clock edges mid-RUN.
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h40 + W'(i));
    @(posedge CLK); #1;
    start = 1'b1; base = 32'h40; limit = 32'h60;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_valid", 64'(counter_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_out", 64'(counter_out), 64'd0);
    chk("async_rst_issued", 64'(issued_count), 64'd0);
    #1 RST = 1'b0;
    exp_q.delete();

    run(32'h30, 32'h31, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
